bus_responder: RTL and testbench

//  Memory/MMIO target for the stack CPU's word bus: drives rdata (the CPU's data_in) and accepts
//  wr/wdata (the CPU's data_out) at a word address. Also sinks the CPU's LEDS/Lr output strobe

---
 rtl/bus_responder.sv | 151 +++++++++++++++
 tb/tb_bus_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// bus_responder: word-bus memory/MMIO target for the stack CPU.
// Holds program/data RAM, an LED latch, an LED event FIFO fed by the CPU's
// Lr strobe, and an optional free-running timer (enabled by defining
// RESPONDER_TIMER_EN; without it 0xFF02 reads 0 and no timer flops exist).
//
// Word address map:
//   0x0000..RAM_DEPTH-1  RAM
//   0xFF00               STATUS {ovf, zero-extended fifo_cnt}; any write clears ovf
//   0xFF01               FIFO head, reading pops once per visit
//   0xFF02               TIMER (reads 0 when the timer is not built)
//   0xFF03               LED latch
module bus_responder #(
  parameter int RAM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      address,
  input  logic [15:0]      wdata,
  input  logic             wr,
  input  logic [7:0]       LEDS,
  input  logic             Lr,
  output logic [15:0]      rdata,
  output logic [7:0]       led_q,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             ovf
);

  localparam int RAM_AW  = $clog2(RAM_DEPTH);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [15:0] RAM_TOP    = 16'(RAM_DEPTH);
  localparam logic [15:0] ADDR_STAT  = 16'hFF00;
  localparam logic [15:0] ADDR_FIFO  = 16'hFF01;
  localparam logic [15:0] ADDR_TIMER = 16'hFF02;
  localparam logic [15:0] ADDR_LED   = 16'hFF03;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [15:0]      ram_mem [RAM_DEPTH];
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  logic [15:0]      rdata_q, rdata_d;
  logic [7:0]       led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             pop_armed_q, pop_armed_d;
  logic [15:0]      timer_rd;

  logic             ram_sel;
  logic             fifo_empty, fifo_full;
  logic             pop_req, do_pop, do_push, overflow;
  logic [7:0]       fifo_head;

  assign ram_sel    = (address < RAM_TOP);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_head  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

  // A pop attempt happens on the first read cycle of a visit to 0xFF01;
  // it only moves the FIFO when there is something to pop.
  assign pop_req  = (address == ADDR_FIFO) && !wr && pop_armed_q;
  assign do_pop   = pop_req && !fifo_empty;
  assign do_push  = Lr && (!fifo_full || do_pop);
  assign overflow = Lr && fifo_full && !do_pop;

`ifdef RESPONDER_TIMER_EN
  logic [15:0] timer_q;

  // Free-running timer, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= 16'h0000;
    else        timer_q <= timer_q + 16'h0001;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = 16'h0000;
`endif

  // Next-state logic for read data, LED latch, FIFO bookkeeping and flags.
  always_comb begin
    rdata_d     = 16'h0000;
    led_d       = led_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_d       = ovf_q;
    pop_armed_d = pop_armed_q;

    if (ram_sel) begin
      rdata_d = ram_mem[address[RAM_AW-1:0]];
    end else begin
      unique case (address)
        ADDR_STAT:  rdata_d = {ovf_q, 15'(cnt_q)};
        ADDR_FIFO:  rdata_d = {8'h00, fifo_head};
        ADDR_TIMER: rdata_d = timer_rd;
        ADDR_LED:   rdata_d = {8'h00, led_q};
        default:    rdata_d = 16'h0000;
      endcase
    end

    if (wr && (address == ADDR_LED)) led_d = wdata[7:0];

    if (address != ADDR_FIFO) pop_armed_d = 1'b1;
    else if (pop_req)         pop_armed_d = 1'b0;

    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);

    // An overflow in the same cycle as a STATUS write keeps the flag set.
    if (overflow)                            ovf_d = 1'b1;
    else if (wr && (address == ADDR_STAT))   ovf_d = 1'b0;
  end

  // Control and status registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q     <= 16'h0000;
      led_q       <= 8'h00;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      pop_armed_q <= 1'b1;
    end else begin
      rdata_q     <= rdata_d;
      led_q       <= led_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      pop_armed_q <= pop_armed_d;
    end
  end

  // RAM and FIFO storage keep their contents across reset; writes are
  // blocked while reset is held so an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr && ram_sel) ram_mem[address[RAM_AW-1:0]] <= wdata;
    if (rst_n && do_push)       fifo_mem[wr_ptr_q] <= LEDS;
  end

  assign rdata    = rdata_q;
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed testbench for bus_responder (default parameters).
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        wr;
  logic [7:0]  LEDS;
  logic        Lr;
  logic [15:0] rdata;
  logic [7:0]  led_q;
  logic [2:0]  fifo_cnt;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  bus_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .wdata    (wdata),
    .wr       (wr),
    .LEDS     (LEDS),
    .Lr       (Lr),
    .rdata    (rdata),
    .led_q    (led_q),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit so outputs can be sampled.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; address = 16'h0000; wdata = 16'h0000; wr = 1'b0;
    LEDS = 8'h00; Lr = 1'b0;
    repeat (2) cyc();
    checks++;
    if (rdata !== 16'h0000 || led_q !== 8'h00 || fifo_cnt !== 3'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdata=%h led=%h cnt=%0d ovf=%b, want 0/0/0/0",
               rdata, led_q, fifo_cnt, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_ram();
    address = 16'h0010; wdata = 16'hBEEF; wr = 1'b1; cyc();
    wr = 1'b0; cyc();
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++; $display("FAIL ram_readback: got %h want BEEF", rdata);
    end
    // read-during-write returns old data, new data the next cycle
    wdata = 16'h1234; wr = 1'b1; cyc();
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++; $display("FAIL ram_rdw_old: got %h want BEEF", rdata);
    end
    wr = 1'b0; cyc();
    checks++;
    if (rdata !== 16'h1234) begin
      errors++; $display("FAIL ram_rdw_new: got %h want 1234", rdata);
    end
    address = 16'h8000; cyc();
    checks++;
    if (rdata !== 16'h0000) begin
      errors++; $display("FAIL unmapped_read: got %h want 0000", rdata);
    end
    // last RAM word, and first address past RAM must not alias to word 0
    address = 16'h0000; wdata = 16'hAAAA; wr = 1'b1; cyc();
    address = 16'h00FF; wdata = 16'h5A5A; cyc();
    address = 16'h0100; wdata = 16'h5555; cyc();
    wr = 1'b0; cyc();
    checks++;
    if (rdata !== 16'h0000) begin
      errors++; $display("FAIL past_ram_read: got %h want 0000", rdata);
    end
    address = 16'h0000; cyc();
    checks++;
    if (rdata !== 16'hAAAA) begin
      errors++; $display("FAIL no_alias: got %h want AAAA", rdata);
    end
    address = 16'h00FF; cyc();
    checks++;
    if (rdata !== 16'h5A5A) begin
      errors++; $display("FAIL ram_top_word: got %h want 5A5A", rdata);
    end
  endtask

  task automatic test_fifo_pop();
    address = 16'h0000;
    Lr = 1'b1; LEDS = 8'h11; cyc();
    LEDS = 8'h22; cyc();
    Lr = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd2) begin
      errors++; $display("FAIL fifo_fill2: cnt=%0d want 2", fifo_cnt);
    end
    address = 16'hFF01; cyc();
    checks++;
    if (rdata !== 16'h0011 || fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL first_pop: rdata=%h cnt=%0d want 0011/1", rdata, fifo_cnt);
    end
    repeat (2) cyc();
    checks++;
    if (fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL held_single_pop: cnt=%0d want 1", fifo_cnt);
    end
    address = 16'h0000; cyc();
    address = 16'hFF01; cyc();
    checks++;
    if (rdata !== 16'h0022 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL second_pop: rdata=%h cnt=%0d want 0022/0", rdata, fifo_cnt);
    end
    address = 16'h0000; cyc();
    address = 16'hFF01; cyc();
    checks++;
    if (rdata !== 16'h0000 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL empty_pop: rdata=%h cnt=%0d want 0000/0", rdata, fifo_cnt);
    end
    address = 16'h0000; cyc();
  endtask

  task automatic test_overflow();
    address = 16'h0000; Lr = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      LEDS = 8'(i); cyc();
    end
    Lr = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd4 || ovf !== 1'b1) begin
      errors++; $display("FAIL overflow_flag: cnt=%0d ovf=%b want 4/1", fifo_cnt, ovf);
    end
    address = 16'hFF00; cyc();
    checks++;
    if (rdata !== 16'h8004) begin
      errors++; $display("FAIL status_read: got %h want 8004", rdata);
    end
    wr = 1'b1; wdata = 16'h0000; cyc();
    wr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL status_clear: ovf=%b want 0", ovf);
    end
    // full + push + pop in the same cycle: push accepted, pre-push head returned
    address = 16'hFF01; Lr = 1'b1; LEDS = 8'h66; cyc();
    Lr = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd4 || ovf !== 1'b0 || rdata !== 16'h0001) begin
      errors++;
      $display("FAIL full_push_pop: cnt=%0d ovf=%b rdata=%h want 4/0/0001", fifo_cnt, ovf, rdata);
    end
    // overflow and STATUS clear in the same cycle: set wins
    address = 16'hFF00; wr = 1'b1; Lr = 1'b1; LEDS = 8'h77; cyc();
    wr = 1'b0; Lr = 1'b0;
    checks++;
    if (ovf !== 1'b1 || fifo_cnt !== 3'd4) begin
      errors++; $display("FAIL set_wins: ovf=%b cnt=%0d want 1/4", ovf, fifo_cnt);
    end
    // remaining order after wrap: 02 03 04 66
    address = 16'hFF01; cyc();
    checks++;
    if (rdata !== 16'h0002) begin
      errors++; $display("FAIL drain_0: got %h want 0002", rdata);
    end
    address = 16'h0000; cyc();
    address = 16'hFF01; cyc();
    address = 16'h0000; cyc();
    address = 16'hFF01; cyc();
    address = 16'h0000; cyc();
    address = 16'hFF01; cyc();
    checks++;
    if (rdata !== 16'h0066 || fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL drain_wrap: rdata=%h cnt=%0d want 0066/0", rdata, fifo_cnt);
    end
    address = 16'h0000; cyc();
  endtask

  task automatic test_led();
    address = 16'hFF03; wdata = 16'h12A5; wr = 1'b1; cyc();
    wr = 1'b0;
    checks++;
    if (led_q !== 8'hA5) begin
      errors++; $display("FAIL led_write: got %h want A5", led_q);
    end
    cyc();
    checks++;
    if (rdata !== 16'h00A5) begin
      errors++; $display("FAIL led_read: got %h want 00A5", rdata);
    end
    address = 16'hFF02; wdata = 16'hFFFF; wr = 1'b1; cyc();
    wr = 1'b0;
    checks++;
    if (led_q !== 8'hA5) begin
      errors++; $display("FAIL timer_write_ignored: led=%h want A5", led_q);
    end
  endtask

  task automatic test_timer();
    logic [15:0] t1;
    logic [15:0] t2;
    address = 16'hFF02; cyc();
`ifdef RESPONDER_TIMER_EN
    t1 = rdata;
    repeat (7) cyc();
    t2 = rdata;
    checks++;
    if (t2 - t1 !== 16'd7) begin
      errors++; $display("FAIL timer_delta: got %0d want 7", t2 - t1);
    end
    force dut.timer_q = 16'hFFFF;
    #1;
    release dut.timer_q;
    cyc();
    checks++;
    if (rdata !== 16'hFFFF) begin
      errors++; $display("FAIL timer_max: got %h want FFFF", rdata);
    end
    cyc();
    checks++;
    if (rdata !== 16'h0000) begin
      errors++; $display("FAIL timer_wrap: got %h want 0000", rdata);
    end
`else
    t1 = rdata;
    repeat (5) cyc();
    t2 = rdata;
    checks++;
    if (t1 !== 16'h0000 || t2 !== 16'h0000) begin
      errors++; $display("FAIL timer_absent: got %h/%h want 0000/0000", t1, t2);
    end
`endif
    address = 16'h0000; cyc();
  endtask

  task automatic test_reset_mid_op();
    address = 16'h0030; wdata = 16'h7777; wr = 1'b1; cyc();
    address = 16'h0020; wdata = 16'h1111; cyc();
    wr = 1'b0; Lr = 1'b1; LEDS = 8'h99; address = 16'h0000; cyc();
    // in-flight write and push, reset asserted before the edge
    address = 16'h0020; wdata = 16'hCAFE; wr = 1'b1; LEDS = 8'h98;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata !== 16'h0000 || led_q !== 8'h00 || fifo_cnt !== 3'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdata=%h led=%h cnt=%0d ovf=%b want 0/0/0/0",
               rdata, led_q, fifo_cnt, ovf);
    end
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; Lr = 1'b0; rst_n = 1'b1;
    address = 16'h0030; cyc();
    checks++;
    if (rdata !== 16'h7777) begin
      errors++; $display("FAIL ram_kept: got %h want 7777", rdata);
    end
    address = 16'h0020; cyc();
    checks++;
    if (rdata !== 16'h1111) begin
      errors++; $display("FAIL write_lost: got %h want 1111", rdata);
    end
    checks++;
    if (fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL fifo_after_reset: cnt=%0d want 0", fifo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_pop();
    test_overflow();
    test_led();
    test_timer();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
